// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: fetch-side lane packet, decoded packet,
// decoder select/function encodings and RV32 opcode constants.
package decode_queue_pkg;

  localparam int DEFAULT_W     = 2;
  localparam int DEFAULT_DEPTH = 8;

  localparam logic [31:0] WFI_INST = 32'h1050_0073;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    OPA_IS_RS1,
    OPA_IS_NPC,
    OPA_IS_PC,
    OPA_IS_ZERO
  } alu_opa_select_e;

  typedef enum logic [2:0] {
    OPB_IS_RS2,
    OPB_IS_I_IMM,
    OPB_IS_S_IMM,
    OPB_IS_B_IMM,
    OPB_IS_U_IMM,
    OPB_IS_J_IMM
  } alu_opb_select_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
  } alu_func_e;

  typedef enum logic [2:0] {
    FU_ALU,
    FU_MULT,
    FU_LOAD,
    FU_STORE,
    FU_BRANCH
  } fu_sel_e;

  // One fetched lane as handed over by fetch.
  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } if_dp_packet_t;

  // One decoded instruction as held in the queue and presented to dispatch.
  typedef struct packed {
    logic [31:0]     inst;
    logic [31:0]     pc;
    logic [31:0]     npc;
    alu_opa_select_e opa_select;
    alu_opb_select_e opb_select;
    alu_func_e       alu_func;
    logic            has_dest;
    logic            rd_mem;
    logic            wr_mem;
    logic            cond_branch;
    logic            uncond_branch;
    logic            csr_op;
    logic            halt;
    logic            illegal;
    fu_sel_e         fu_sel;
    logic            has_rs1;
    logic            has_rs2;
    logic            valid;
  } decoded_packet_t;

endpackage

// File: rtl/decode_queue_decoder.sv
// Single-lane RV32IM decoder (purely combinational).
// Ports:
//   if_packet  in   fetched lane (inst, pc, npc, valid)
//   id_packet  out  decoded lane; control fields are inert when valid = 0
// Unknown or reserved encodings set illegal = 1 and are otherwise inert.
module decode_queue_decoder
  import decode_queue_pkg::*;
(
  input  if_dp_packet_t   if_packet,
  output decoded_packet_t id_packet
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = if_packet.inst[6:0];
  assign funct3 = if_packet.inst[14:12];
  assign funct7 = if_packet.inst[31:25];

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves
    // a field unassigned, which would otherwise infer a latch.
    id_packet               = '0;
    id_packet.inst          = if_packet.inst;
    id_packet.pc            = if_packet.pc;
    id_packet.npc           = if_packet.npc;
    id_packet.valid         = if_packet.valid;
    id_packet.opa_select    = OPA_IS_RS1;
    id_packet.opb_select    = OPB_IS_RS2;
    id_packet.alu_func      = ALU_ADD;
    id_packet.fu_sel        = FU_ALU;

    if (if_packet.valid) begin
      case (opcode)
        OPC_LUI: begin
          id_packet.has_dest   = 1'b1;
          id_packet.opa_select = OPA_IS_ZERO;
          id_packet.opb_select = OPB_IS_U_IMM;
        end
        OPC_AUIPC: begin
          id_packet.has_dest   = 1'b1;
          id_packet.opa_select = OPA_IS_PC;
          id_packet.opb_select = OPB_IS_U_IMM;
        end
        OPC_JAL: begin
          id_packet.has_dest      = 1'b1;
          id_packet.opa_select    = OPA_IS_PC;
          id_packet.opb_select    = OPB_IS_J_IMM;
          id_packet.uncond_branch = 1'b1;
          id_packet.fu_sel        = FU_BRANCH;
        end
        OPC_JALR: begin
          id_packet.has_dest      = 1'b1;
          id_packet.has_rs1       = 1'b1;
          id_packet.opb_select    = OPB_IS_I_IMM;
          id_packet.uncond_branch = 1'b1;
          id_packet.fu_sel        = FU_BRANCH;
          id_packet.illegal       = (funct3 != 3'b000);
        end
        OPC_BRANCH: begin
          id_packet.has_rs1     = 1'b1;
          id_packet.has_rs2     = 1'b1;
          id_packet.opa_select  = OPA_IS_PC;
          id_packet.opb_select  = OPB_IS_B_IMM;
          id_packet.cond_branch = 1'b1;
          id_packet.fu_sel      = FU_BRANCH;
          id_packet.illegal     = (funct3 == 3'b010) || (funct3 == 3'b011);
        end
        OPC_LOAD: begin
          id_packet.has_dest   = 1'b1;
          id_packet.has_rs1    = 1'b1;
          id_packet.opb_select = OPB_IS_I_IMM;
          id_packet.rd_mem     = 1'b1;
          id_packet.fu_sel     = FU_LOAD;
          id_packet.illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end
        OPC_STORE: begin
          id_packet.has_rs1    = 1'b1;
          id_packet.has_rs2    = 1'b1;
          id_packet.opb_select = OPB_IS_S_IMM;
          id_packet.wr_mem     = 1'b1;
          id_packet.fu_sel     = FU_STORE;
          id_packet.illegal    = (funct3 > 3'b010);
        end
        OPC_OP_IMM: begin
          id_packet.has_dest   = 1'b1;
          id_packet.has_rs1    = 1'b1;
          id_packet.opb_select = OPB_IS_I_IMM;
          case (funct3)
            3'b000: id_packet.alu_func = ALU_ADD;
            3'b010: id_packet.alu_func = ALU_SLT;
            3'b011: id_packet.alu_func = ALU_SLTU;
            3'b100: id_packet.alu_func = ALU_XOR;
            3'b110: id_packet.alu_func = ALU_OR;
            3'b111: id_packet.alu_func = ALU_AND;
            3'b001: begin
              id_packet.alu_func = ALU_SLL;
              id_packet.illegal  = (funct7 != 7'b0000000);
            end
            default: begin  // 3'b101: shift right, funct7 picks arithmetic
              id_packet.alu_func = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
              id_packet.illegal  = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
          endcase
        end
        OPC_OP: begin
          id_packet.has_dest = 1'b1;
          id_packet.has_rs1  = 1'b1;
          id_packet.has_rs2  = 1'b1;
          case (funct7)
            7'b0000000: begin
              case (funct3)
                3'b000:  id_packet.alu_func = ALU_ADD;
                3'b001:  id_packet.alu_func = ALU_SLL;
                3'b010:  id_packet.alu_func = ALU_SLT;
                3'b011:  id_packet.alu_func = ALU_SLTU;
                3'b100:  id_packet.alu_func = ALU_XOR;
                3'b101:  id_packet.alu_func = ALU_SRL;
                3'b110:  id_packet.alu_func = ALU_OR;
                default: id_packet.alu_func = ALU_AND;
              endcase
            end
            7'b0100000: begin
              case (funct3)
                3'b000:  id_packet.alu_func = ALU_SUB;
                3'b101:  id_packet.alu_func = ALU_SRA;
                default: id_packet.illegal  = 1'b1;
              endcase
            end
            7'b0000001: begin
              // Only the multiply half of the M extension is implemented;
              // divide encodings (funct3[2] set) are flagged illegal.
              id_packet.fu_sel = FU_MULT;
              case (funct3)
                3'b000:  id_packet.alu_func = ALU_MUL;
                3'b001:  id_packet.alu_func = ALU_MULH;
                3'b010:  id_packet.alu_func = ALU_MULHSU;
                3'b011:  id_packet.alu_func = ALU_MULHU;
                default: id_packet.illegal  = 1'b1;
              endcase
            end
            default: id_packet.illegal = 1'b1;
          endcase
        end
        OPC_FENCE: begin
          // Single in-order core: fences decode as no-ops.
        end
        OPC_SYSTEM: begin
          if (if_packet.inst == WFI_INST) begin
            id_packet.halt = 1'b1;
          end else if ((funct3 != 3'b000) && (funct3 != 3'b100)) begin
            id_packet.csr_op   = 1'b1;
            id_packet.has_dest = 1'b1;
            id_packet.has_rs1  = ~funct3[2];  // CSRRxI forms use a zimm
          end else begin
            id_packet.illegal = 1'b1;
          end
        end
        default: id_packet.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/decode_queue.sv
// W-wide decode stage feeding an in-order circular buffer of decoded
// instructions, sitting between fetch and dispatch.
// Ports:
//   clock         in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   flush         in   squash buffered and incoming instructions
//   if_packet     in   W fetched lanes; lane i used only when valid
//   if_ready      out  fetch may present lanes this cycle
//   dp_packet     out  W oldest entries, lane 0 oldest
//   dp_valid      out  thermometer code, dp_valid[i] = (count > i)
//   dp_pop        in   lanes consumed by dispatch this cycle
//   free_slots    out  DEPTH - count
//   halt_pending  out  a WFI is buffered and not yet flushed
// DEPTH must be a power of two and at least 2*W; W is 1..4.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  if_dp_packet_t          if_packet [W],
  output logic                   if_ready,
  output decoded_packet_t        dp_packet [W],
  output logic [W-1:0]           dp_valid,
  input  logic [$clog2(W+1)-1:0] dp_pop,
  output logic [CNT_W-1:0]       free_slots,
  output logic                   halt_pending
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LANE_W = $clog2(W + 1);

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic              halt_q;

  decoded_packet_t   entries [DEPTH];
  decoded_packet_t   dec     [W];

  logic              accept;
  logic [W-1:0]      lane_keep;
  logic [LANE_W-1:0] lane_off [W];
  logic [LANE_W-1:0] push_cnt;
  logic              halt_push;

  // ---------------------------------------------------------------------
  // Per-lane decode
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < W; i++) begin : g_dec
    decode_queue_decoder u_decoder (
      .if_packet (if_packet[i]),
      .id_packet (dec[i])
    );
  end

  // ---------------------------------------------------------------------
  // Acceptance: only registered state feeds if_ready, so dispatch's
  // dp_pop never reaches fetch combinationally. Requiring room for a
  // full group means any mix of valid lanes always fits.
  // ---------------------------------------------------------------------
  assign free_slots   = CNT_W'(DEPTH) - count;
  assign halt_pending = halt_q;
  assign if_ready     = (free_slots >= CNT_W'(W)) & ~halt_q;
  assign accept       = if_ready & ~flush;

  // ---------------------------------------------------------------------
  // Compaction and halt fence: a running count of kept lanes gives each
  // lane its slot offset from tail; once a kept lane decodes as halt the
  // younger lanes of the same group are dropped.
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: blocking assignments here are deliberate; push_cnt and
    // halt_push are read back within the same pass to build the prefix sum.
    push_cnt  = '0;
    halt_push = 1'b0;
    lane_keep = '0;
    for (int i = 0; i < W; i++) begin
      lane_off[i]  = push_cnt;
      lane_keep[i] = accept & if_packet[i].valid & ~halt_push;
      if (lane_keep[i]) begin
        push_cnt = push_cnt + LANE_W'(1);
        if (dec[i].halt) halt_push = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------
  // NOTE: the payload array has no reset; occupancy is tracked by the
  // pointers and count, so stale contents are never presented as valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < W; i++) begin
      if (lane_keep[i]) entries[tail + PTR_W'(lane_off[i])] <= dec[i];
    end
  end

  // ---------------------------------------------------------------------
  // Pointers, occupancy and halt latch. Pointers are exactly log2(DEPTH)
  // bits wide so they wrap for free. A pop frees slots only from the next
  // cycle on, since acceptance was decided on the pre-pop count.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      halt_q <= 1'b0;
    end else if (flush) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      halt_q <= 1'b0;
    end else begin
      head   <= head + PTR_W'(dp_pop);
      tail   <= tail + PTR_W'(push_cnt);
      count  <= count - CNT_W'(dp_pop) + CNT_W'(push_cnt);
      halt_q <= halt_q | halt_push;
    end
  end

  // ---------------------------------------------------------------------
  // Dispatch window
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < W; i++) begin : g_dp
    assign dp_packet[i] = entries[head + PTR_W'(i)];
    assign dp_valid[i]  = (count > CNT_W'(i));
  end

  // Dispatch may never consume more lanes than are marked valid.
  a_pop_legal: assert property (@(posedge clock) disable iff (!reset_n)
    (CNT_W'(dp_pop) <= count) && (int'(dp_pop) <= W));

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue (W=2, DEPTH=8). A scoreboard queue
// holds the expected decoded entries in FIFO order; outputs are compared
// one time unit after each rising edge, before new inputs are applied.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int W     = 2;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Instruction table indices
  localparam int I_ADDI = 0;
  localparam int I_ADD  = 1;
  localparam int I_MUL  = 2;
  localparam int I_LW   = 3;
  localparam int I_SW   = 4;
  localparam int I_BEQ  = 5;
  localparam int I_ILL  = 6;
  localparam int I_WFI  = 7;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [15:0] ctrl;
  } exp_t;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic                   flush;
  if_dp_packet_t          if_packet [W];
  logic                   if_ready;
  decoded_packet_t        dp_packet [W];
  logic [W-1:0]           dp_valid;
  logic [$clog2(W+1)-1:0] dp_pop;
  logic [CNT_W-1:0]       free_slots;
  logic                   halt_pending;

  logic [31:0] inst_tab [8];
  logic [15:0] ctrl_tab [8];
  exp_t        sb [$];
  bit          halt_m;
  logic [31:0] pc_ctr;
  int          n_vec;
  int          n_err;

  decode_queue #(.W(W), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .if_packet    (if_packet),
    .if_ready     (if_ready),
    .dp_packet    (dp_packet),
    .dp_valid     (dp_valid),
    .dp_pop       (dp_pop),
    .free_slots   (free_slots),
    .halt_pending (halt_pending)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ctrl_bits(input fu_sel_e fu, input alu_opb_select_e opb,
                                            input logic r1, input logic r2,
                                            input logic h, input logic il);
    return {6'b0, fu, opb, r1, r2, h, il};
  endfunction

  function automatic if_dp_packet_t mk(input int idx, input bit v, input logic [31:0] pc);
    if_dp_packet_t p;
    p.valid = v;
    p.inst  = inst_tab[idx];
    p.pc    = pc;
    p.npc   = pc + 32'd4;
    return p;
  endfunction

  // Compare visible state against the model, apply one cycle of stimulus,
  // advance the model, then step past the next rising edge.
  task automatic step(input int i0, input bit v0, input int i1, input bit v1,
                      input int pop, input bit fl);
    logic [W-1:0] exp_valid;
    bit           ready_m;
    bit           seen;
    int           idx [W];
    bit           vld [W];

    ready_m = ((DEPTH - sb.size()) >= W) && !halt_m;
    for (int i = 0; i < W; i++) exp_valid[i] = (sb.size() > i);
    check("if_ready", 64'(if_ready), 64'(ready_m));
    check("free_slots", 64'(free_slots), 64'(DEPTH - sb.size()));
    check("dp_valid", 64'(dp_valid), 64'(exp_valid));
    check("halt_pending", 64'(halt_pending), 64'(halt_m));
    for (int i = 0; i < W; i++) begin
      if (i < sb.size()) begin
        check($sformatf("lane%0d_inst", i), 64'(dp_packet[i].inst), 64'(sb[i].inst));
        check($sformatf("lane%0d_pc", i), 64'(dp_packet[i].pc), 64'(sb[i].pc));
        check($sformatf("lane%0d_ctrl", i),
              64'(ctrl_bits(dp_packet[i].fu_sel, dp_packet[i].opb_select,
                            dp_packet[i].has_rs1, dp_packet[i].has_rs2,
                            dp_packet[i].halt, dp_packet[i].illegal)),
              64'(sb[i].ctrl));
      end
    end

    idx[0] = i0; idx[1] = i1;
    vld[0] = v0; vld[1] = v1;
    for (int i = 0; i < W; i++) begin
      if_packet[i] = mk(idx[i], vld[i], pc_ctr);
      pc_ctr       = pc_ctr + 32'd4;
    end
    dp_pop = 2'(pop);
    flush  = fl;

    if (fl) begin
      sb.delete();
      halt_m = 1'b0;
    end else begin
      for (int p = 0; p < pop; p++) void'(sb.pop_front());
      seen = 1'b0;
      if (ready_m) begin
        for (int i = 0; i < W; i++) begin
          if (vld[i] && !seen) begin
            sb.push_back('{inst: inst_tab[idx[i]], pc: if_packet[i].pc, ctrl: ctrl_tab[idx[i]]});
            if (idx[i] == I_WFI) seen = 1'b1;
          end
        end
      end
      halt_m = halt_m | seen;
    end

    @(posedge clock);
    #1;
  endtask

  function automatic int max_pop();
    return (sb.size() < W) ? sb.size() : W;
  endfunction

  initial begin
    n_vec  = 0;
    n_err  = 0;
    halt_m = 1'b0;
    pc_ctr = 32'h0000_1000;

    inst_tab[I_ADDI] = 32'h0050_0093;  ctrl_tab[I_ADDI] = ctrl_bits(FU_ALU,    OPB_IS_I_IMM, 1, 0, 0, 0);
    inst_tab[I_ADD]  = 32'h0020_81B3;  ctrl_tab[I_ADD]  = ctrl_bits(FU_ALU,    OPB_IS_RS2,   1, 1, 0, 0);
    inst_tab[I_MUL]  = 32'h0241_82B3;  ctrl_tab[I_MUL]  = ctrl_bits(FU_MULT,   OPB_IS_RS2,   1, 1, 0, 0);
    inst_tab[I_LW]   = 32'h0080_A303;  ctrl_tab[I_LW]   = ctrl_bits(FU_LOAD,   OPB_IS_I_IMM, 1, 0, 0, 0);
    inst_tab[I_SW]   = 32'h0020_A223;  ctrl_tab[I_SW]   = ctrl_bits(FU_STORE,  OPB_IS_S_IMM, 1, 1, 0, 0);
    inst_tab[I_BEQ]  = 32'h0020_8463;  ctrl_tab[I_BEQ]  = ctrl_bits(FU_BRANCH, OPB_IS_B_IMM, 1, 1, 0, 0);
    inst_tab[I_ILL]  = 32'hFFFF_FFFF;  ctrl_tab[I_ILL]  = ctrl_bits(FU_ALU,    OPB_IS_RS2,   0, 0, 0, 1);
    inst_tab[I_WFI]  = 32'h1050_0073;  ctrl_tab[I_WFI]  = ctrl_bits(FU_ALU,    OPB_IS_RS2,   0, 0, 1, 0);

    reset_n = 1'b0;
    flush   = 1'b0;
    dp_pop  = '0;
    for (int i = 0; i < W; i++) if_packet[i] = mk(I_ADDI, 1'b0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Reset state, then two-lane push, then compaction of a single lane.
    step(I_ADDI, 1, I_ADD, 1, 0, 0);
    step(I_ADDI, 0, I_MUL, 1, 0, 0);
    step(I_LW,   1, I_SW,  1, 0, 0);
    step(I_BEQ,  1, I_ILL, 1, 0, 0);
    // Seven entries: fetch must be stalled; the offered group is ignored.
    step(I_ADDI, 1, I_ADD, 1, 0, 0);
    step(I_ADDI, 0, I_ADD, 0, 2, 0);

    // Mixed push/pop traffic across the pointer wrap.
    for (int k = 0; k < 12; k++) begin
      step($urandom_range(0, 6), 1'($urandom_range(0, 1)),
           $urandom_range(0, 6), 1'($urandom_range(0, 1)),
           $urandom_range(0, max_pop()), 0);
    end
    for (int k = 0; k < 8; k++) begin
      if (sb.size() > 0) step(I_ADDI, 0, I_ADDI, 0, max_pop(), 0);
    end

    // Halt fence: WFI enqueued, the younger ADDI dropped, then fetch stalls
    // until a flush clears everything.
    step(I_WFI,  1, I_ADDI, 1, 0, 0);
    step(I_ADDI, 1, I_ADD,  1, 0, 0);
    step(I_ADDI, 1, I_ADD,  1, 0, 1);
    step(I_MUL,  1, I_BEQ,  1, 0, 0);
    step(I_ADDI, 0, I_ADDI, 0, 2, 0);

    // Flush together with a pop and a valid push.
    step(I_ADDI, 1, I_ADD, 1, 0, 0);
    step(I_LW,   1, I_SW,  1, 2, 1);
    step(I_MUL,  1, I_BEQ, 1, 0, 0);

    // Reset asserted between edges must clear the queue immediately.
    for (int i = 0; i < W; i++) if_packet[i].valid = 1'b0;
    dp_pop = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_dp_valid", 64'(dp_valid), 64'(0));
    check("async_free_slots", 64'(free_slots), 64'(DEPTH));
    check("async_if_ready", 64'(if_ready), 64'(1));
    sb.delete();
    halt_m = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(I_ADDI, 0, I_ADDI, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
